// File: rtl/ext_sram_target.sv
// Byte-wide external SRAM responder with fixed read latency and preload port.
// Optional read/write counters: define EXT_SRAM_TARGET_STATS_EN.
module ext_sram_target #(
  parameter int AddrWidth   = 16,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          ext_sram_addr_i,
  input  logic [7:0]           ext_sram_wdata_i,
  input  logic                 ext_sram_read_i,
  input  logic                 ext_sram_write_i,
  output logic [7:0]           ext_sram_rdata_o,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [AddrWidth-1:0] load_addr_i,
  input  logic [7:0]           load_data_i,
`ifdef EXT_SRAM_TARGET_STATS_EN
  output logic [31:0]          rd_count_o,
  output logic [31:0]          wr_count_o,
`endif
  output logic                 err_o
);

  localparam int Depth = 1 << AddrWidth;

  logic [7:0]           mem [Depth];
  logic                 in_range;
  logic [AddrWidth-1:0] idx;
  logic                 bus_wr;
  logic                 rd_acc;
  logic                 load_wr;
  logic                 err_set;
  logic [7:0]           rd_byte;

  logic [7:0]             pd [ReadLatency];
  logic [ReadLatency-1:0] pv;

  assign in_range = (ext_sram_addr_i >> AddrWidth) == 32'd0;
  assign idx      = ext_sram_addr_i[AddrWidth-1:0];
  assign bus_wr   = ext_sram_write_i & ~rst_i;
  assign rd_acc   = ext_sram_read_i & ~ext_sram_write_i & ~rst_i;

  assign load_ready_o = ~rst_i & ~ext_sram_read_i & ~ext_sram_write_i;
  assign load_wr      = load_valid_i & load_ready_o;

  assign err_set = ((ext_sram_read_i | ext_sram_write_i) & ~in_range)
                 | (ext_sram_read_i & ext_sram_write_i);

  assign rd_byte = in_range ? mem[idx] : 8'h00;

  // Array storage: bus writes and host preloads, never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (bus_wr && in_range) begin
      mem[idx] <= ext_sram_wdata_i;
    end else if (load_wr) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  // Read pipeline: sample at issue, shift, publish from the last stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv               <= '0;
      ext_sram_rdata_o <= 8'h00;
    end else begin
      pv[0] <= rd_acc;
      pd[0] <= rd_byte;
      for (int i = 1; i < ReadLatency; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (pv[ReadLatency-1]) begin
        ext_sram_rdata_o <= pd[ReadLatency-1];
      end
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end
  end

`ifdef EXT_SRAM_TARGET_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  assign rd_count_o = rd_cnt;
  assign wr_count_o = wr_cnt;

  // Saturating access counters; preloads are not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else begin
      if (rd_acc && rd_cnt != 32'hFFFF_FFFF) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (bus_wr && wr_cnt != 32'hFFFF_FFFF) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ext_sram_target.sv
// Randomized scoreboard bench for ext_sram_target.
// Reference model: associative byte array plus due-edge read queue.
module tb_ext_sram_target;

  localparam int AW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   addr = '0;
  logic [7:0]    wdata = '0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [7:0]    rdata;
  logic          lvalid = 1'b0;
  logic          lready;
  logic [AW-1:0] laddr = '0;
  logic [7:0]    ldata = '0;
  logic          err;
`ifdef EXT_SRAM_TARGET_STATS_EN
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
  logic [31:0]   m_rd = 0;
  logic [31:0]   m_wr = 0;
`endif

  ext_sram_target #(.AddrWidth(AW), .ReadLatency(LAT)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ext_sram_addr_i  (addr),
    .ext_sram_wdata_i (wdata),
    .ext_sram_read_i  (rd),
    .ext_sram_write_i (wr),
    .ext_sram_rdata_o (rdata),
    .load_valid_i     (lvalid),
    .load_ready_o     (lready),
    .load_addr_i      (laddr),
    .load_data_i      (ldata),
`ifdef EXT_SRAM_TARGET_STATS_EN
    .rd_count_o       (rd_count),
    .wr_count_o       (wr_count),
`endif
    .err_o            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    logic [7:0] d;
    bit       chk;
  } exp_t;

  exp_t       sbq [$];
  logic [7:0] mm [logic [15:0]];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         mon_en = 0;
  bit         m_err = 0;
  logic [7:0] exp_rd = 0;
  bit         exp_known = 1;
  bit         acc;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: retire due reads and compare every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_known = sbq[0].chk;
        exp_rd    = sbq[0].d;
        void'(sbq.pop_front());
      end
      if (exp_known) check("rdata", {24'h0, rdata}, {24'h0, exp_rd});
      check("err", {31'h0, err}, {31'h0, m_err});
`ifdef EXT_SRAM_TARGET_STATS_EN
      check("rd_count", rd_count, m_rd);
      check("wr_count", wr_count, m_wr);
`endif
    end
  end

  task automatic step(input bit r, input bit w, input logic [31:0] a,
                      input logic [7:0] wd, input bit lv,
                      input logic [15:0] la, input logic [7:0] ld,
                      output bit accepted);
    bit   inr;
    exp_t e;
    rd = r; wr = w; addr = a; wdata = wd;
    lvalid = lv; laddr = la; ldata = ld;
    inr = (a >> AW) == 0;
    if (r && !w) begin
      e.due = cyc + 1 + LAT;
      e.d   = 8'h00;
      e.chk = 1;
      if (inr) begin
        if (mm.exists(a[15:0])) e.d = mm[a[15:0]];
        else e.chk = 0;
      end
      sbq.push_back(e);
    end
    #1;
    check("load_ready", {31'h0, lready}, {31'h0, !(r || w)});
    accepted = lv && !(r || w);
    @(posedge clk);
    if (w && inr) mm[a[15:0]] = wd;
    if (accepted) mm[la] = ld;
    if (((r || w) && !inr) || (r && w)) m_err = 1;
`ifdef EXT_SRAM_TARGET_STATS_EN
    if (r && !w && m_rd != 32'hFFFF_FFFF) m_rd++;
    if (w && m_wr != 32'hFFFF_FFFF) m_wr++;
`endif
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic bus_rd(input logic [31:0] a);
    bit x;
    step(1, 0, a, 0, 0, 0, 0, x);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    bit x;
    step(0, 1, a, d, 0, 0, 0, x);
  endtask

  task automatic do_reset();
    rst = 1; rd = 0; wr = 0; lvalid = 0;
    #1;
    check("load_ready_rst", {31'h0, lready}, 32'h0);
    @(posedge clk);
    sbq.delete();
    m_err = 0;
    exp_rd = 0;
    exp_known = 1;
`ifdef EXT_SRAM_TARGET_STATS_EN
    m_rd = 0;
    m_wr = 0;
`endif
    @(negedge clk);
    rst = 0;
    mon_en = 1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(1);

    // basic write/read, exact latency checked by monitor hold compare
    bus_wr(32'h10, 8'hA5);
    bus_rd(32'h10);
    idle(LAT + 1);

    // preload then stream
    step(0, 0, 0, 0, 1, 16'h0, 8'h11, acc);
    check("load_acc0", {31'h0, acc}, 32'h1);
    step(0, 0, 0, 0, 1, 16'h1, 8'h22, acc);
    step(0, 0, 0, 0, 1, 16'h2, 8'h33, acc);
    step(0, 0, 0, 0, 1, 16'h3, 8'h44, acc);
    for (int i = 0; i < 4; i++) bus_rd(i);
    idle(LAT + 1);

    // out of range read, dropped write, no aliasing
    bus_rd(32'h0001_0000);
    bus_wr(32'h0001_0000, 8'h77);
    bus_rd(32'h0000_0000);
    idle(LAT + 1);
    check("mem0_intact", {24'h0, rdata}, 32'h11);

    do_reset();
    // strobe conflict
    step(1, 1, 32'h20, 8'h5A, 0, 0, 0, acc);
    idle(LAT + 1);
    bus_rd(32'h20);
    idle(LAT + 1);
    check("conflict_wr", {24'h0, rdata}, 32'h5A);

    // load held across bus burst
    step(1, 0, 32'h1, 0, 1, 16'h40, 8'hC3, acc);
    check("hold0", {31'h0, acc}, 32'h0);
    step(0, 1, 32'h2, 8'h99, 1, 16'h40, 8'hC3, acc);
    check("hold1", {31'h0, acc}, 32'h0);
    step(1, 0, 32'h3, 0, 1, 16'h40, 8'hC3, acc);
    check("hold2", {31'h0, acc}, 32'h0);
    step(0, 0, 0, 0, 1, 16'h40, 8'hC3, acc);
    check("hold_done", {31'h0, acc}, 32'h1);
    bus_rd(32'h40);
    idle(LAT + 1);

    // reset with a read in flight
    do_reset();
    bus_rd(32'h10);
    do_reset();
    idle(LAT + 2);
    check("rst_mid_rd", {24'h0, rdata}, 32'h0);
    bus_rd(32'h10);
    idle(LAT + 1);
    check("survive_rst", {24'h0, rdata}, 32'hA5);

`ifdef EXT_SRAM_TARGET_STATS_EN
    do_reset();
    bus_rd(1); bus_rd(2); bus_rd(3);
    bus_wr(5, 8'h1); bus_wr(6, 8'h2);
    idle(1);
    check("rd3", rd_count, 32'd3);
    check("wr2", wr_count, 32'd2);
    force dut.rd_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.rd_cnt;
    m_rd = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_rd(1);
    idle(1);
    check("rd_sat", rd_count, 32'hFFFF_FFFF);
`endif

    // randomized traffic
    for (int it = 0; it < 500; it++) begin
      int          op;
      logic [31:0] a;
      bit          r, w;
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        op = $urandom_range(0, 7);
        r  = (op <= 2) || (op == 5);
        w  = (op == 3) || (op == 4) || (op == 5);
        a  = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0)
          a = a | (32'($urandom_range(1, 65535)) << 16);
        step(r, w, a, 8'($urandom), $urandom_range(0, 1) == 1,
             16'($urandom_range(0, 15)), 8'($urandom), acc);
      end
    end
    idle(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
